easyaxi_ar_arb: RTL and testbench

- Round-robin arbiter that shares one AXI AR slave port (the EasyAXI slave AR channel) between NUM_MST requesting masters.
- Holds the winning request in a one-entry output register, tags it with the winner's index, and presents it downstream with AXI-compliant valid/ready behaviour.
- Sits between the master-side AR ports and the single slave AR input.

---
 rtl/easyaxi_ar_arb.sv | 102 ++++++++++
 tb/tb_easyaxi_ar_arb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/easyaxi_ar_arb.sv
// Round-robin arbiter sharing one EasyAXI AR slave port between NUM_MST masters.
// The winning request is held in a one-entry output register tagged with its master index.
module easyaxi_ar_arb #(
    parameter int NUM_MST = 4,
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NUM_MST-1:0]        mst_arvalid,
    output logic [NUM_MST-1:0]        mst_arready,
    input  logic [NUM_MST*ADDR_W-1:0] mst_araddr,
    output logic                      slv_arvalid,
    input  logic                      slv_arready,
    output logic [ADDR_W-1:0]         slv_araddr,
    output logic [ID_W-1:0]           slv_arid,
    output logic                      busy
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ID_W-1:0]   sel;
    logic [ADDR_W-1:0] sel_addr;
    logic              found;
    logic              can_load;
    logic              capture;

    // Two passes: indices above last_q first, then wrap to the low indices.
    always_comb begin
        sel      = '0;
        sel_addr = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (!found && mst_arvalid[i] && (i > int'(last_q))) begin
                sel      = ID_W'(i);
                sel_addr = mst_araddr[i*ADDR_W +: ADDR_W];
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_MST; i++) begin
            if (!found && mst_arvalid[i] && (i <= int'(last_q))) begin
                sel      = ID_W'(i);
                sel_addr = mst_araddr[i*ADDR_W +: ADDR_W];
                found    = 1'b1;
            end
        end
    end

    // slv_arready only affects the master side through can_load.
    assign can_load = enable & ((state_q == EMPTY) | slv_arready);
    assign capture  = can_load & found & rst_n;

    always_comb begin
        mst_arready = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (ID_W'(i) == sel) begin
                mst_arready[i] = capture;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        addr_d  = addr_q;
        if (capture) begin
            state_d = FULL;
            last_d  = sel;
            id_d    = sel;
            addr_d  = sel_addr;
        end else if ((state_q == FULL) && slv_arready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            last_q  <= ID_W'(NUM_MST - 1);
            id_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
        end
    end

    assign slv_arvalid = (state_q == FULL);
    assign slv_araddr  = addr_q;
    assign slv_arid    = id_q;
    assign busy        = (state_q == FULL);

endmodule

// File: tb/tb_easyaxi_ar_arb.sv
// Scoreboard bench for easyaxi_ar_arb: a reference arbiter predicts grants and
// queues each captured beat, which is popped when the slave handshake is due.
module tb_easyaxi_ar_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [N-1:0]    mst_arvalid;
    logic [N-1:0]    mst_arready;
    logic [N*AW-1:0] mst_araddr;
    logic            slv_arvalid;
    logic            slv_arready;
    logic [AW-1:0]   slv_araddr;
    logic [IW-1:0]   slv_arid;
    logic            busy;

    always #5 clk = ~clk;

    easyaxi_ar_arb #(.NUM_MST(N), .ADDR_W(AW), .ID_W(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mst_arvalid (mst_arvalid),
        .mst_arready (mst_arready),
        .mst_araddr  (mst_araddr),
        .slv_arvalid (slv_arvalid),
        .slv_arready (slv_arready),
        .slv_araddr  (slv_araddr),
        .slv_arid    (slv_arid),
        .busy        (busy)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
    } beat_t;

    beat_t        sb[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           m_last;
    bit           m_full;
    bit           m_cap;
    int           m_win;
    bit           exp_pop;
    logic [N-1:0] exp_rdy;

    function automatic int ref_winner(input logic [N-1:0] v, input int last);
        logic [1:0] idx;
        for (int k = 1; k <= N; k++) begin
            idx = 2'((last + k) % N);
            if (v[idx]) return int'(idx);
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = N - 1;
        m_full = 1'b0;
        m_cap  = 1'b0;
        exp_pop = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus and predict the arbiter's response.
    task automatic apply(input logic en, input logic [N-1:0] v, input logic sr);
        enable      = en;
        mst_arvalid = v;
        slv_arready = sr;
        #1;
        exp_pop = m_full && sr;
        m_win   = ref_winner(v, m_last);
        m_cap   = en && (!m_full || sr) && (m_win >= 0);
        exp_rdy = '0;
        if (m_cap) begin
            exp_rdy[m_win[1:0]] = 1'b1;
            sb.push_back('{id: IW'(m_win), addr: AW'(mst_araddr >> (m_win * AW))});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (exp_pop) m_full = 1'b0;
        if (m_cap) begin
            m_full = 1'b1;
            m_last = m_win;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        beat_t b;
        rst_n       = 1'b0;
        enable      = 1'b1;
        mst_arvalid = '1;
        slv_arready = 1'b1;
        for (int i = 0; i < N; i++) mst_araddr[i*AW +: AW] = 32'h5000 + 32'(i);
        @(posedge clk);
        #1;
        n_cmp++; if (slv_arvalid !== 1'b0) begin n_err++; $display("FAIL reset_arvalid: got %b want 0", slv_arvalid); end
        n_cmp++; if (slv_araddr !== '0) begin n_err++; $display("FAIL reset_araddr: got %h want 0", slv_araddr); end
        n_cmp++; if (slv_arid !== '0) begin n_err++; $display("FAIL reset_arid: got %0d want 0", slv_arid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (mst_arready !== '0) begin n_err++; $display("FAIL reset_arready: got %b want 0000", mst_arready); end
        rst_n = 1'b1;
        model_reset();
        apply(1'b1, 4'b1111, 1'b1);
        n_cmp++; if (mst_arready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b want 0001", mst_arready); end
        step();
        apply(1'b1, 4'b0000, 1'b1);
        if (exp_pop) begin
            b = sb.pop_front();
            n_cmp++; if (slv_arid !== b.id || slv_araddr !== b.addr) begin n_err++; $display("FAIL reset_beat: got id %0d addr %h want id %0d addr %h", slv_arid, slv_araddr, b.id, b.addr); end
        end
        step();
    endtask

    task automatic test_single();
        logic [5:0] tbl [5] = '{6'b1_0001_1, 6'b1_0001_1, 6'b1_0001_1, 6'b1_0000_1, 6'b1_0000_1};
        logic [5:0] t;
        beat_t b;
        do_reset();
        mst_araddr = '0;
        mst_araddr[0 +: AW] = 32'h1000;
        for (int c = 0; c < 5; c++) begin
            t = tbl[c];
            apply(t[5], t[4:1], t[0]);
            n_cmp++; if (mst_arready !== exp_rdy) begin n_err++; $display("FAIL single_ready c%0d: got %b want %b", c, mst_arready, exp_rdy); end
            n_cmp++; if (slv_arvalid !== m_full || busy !== m_full) begin n_err++; $display("FAIL single_valid c%0d: got %b/%b want %b", c, slv_arvalid, busy, m_full); end
            if (exp_pop) begin
                b = sb.pop_front();
                n_cmp++; if (slv_arid !== b.id || slv_araddr !== b.addr) begin n_err++; $display("FAIL single_beat c%0d: got id %0d addr %h want id %0d addr %h", c, slv_arid, slv_araddr, b.id, b.addr); end
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        beat_t b;
        do_reset();
        for (int i = 0; i < N; i++) mst_araddr[i*AW +: AW] = 32'(32'h100 * i);
        for (int c = 0; c < 11; c++) begin
            apply(1'b1, (c < 10) ? 4'b1111 : 4'b0000, 1'b1);
            n_cmp++; if (mst_arready !== exp_rdy) begin n_err++; $display("FAIL rr_ready c%0d: got %b want %b", c, mst_arready, exp_rdy); end
            if (c < 10) begin
                n_cmp++; if (mst_arready !== (4'b0001 << (c % 4))) begin n_err++; $display("FAIL rr_order c%0d: got %b want master %0d", c, mst_arready, c % 4); end
            end
            n_cmp++; if (slv_arvalid !== m_full || busy !== m_full) begin n_err++; $display("FAIL rr_valid c%0d: got %b/%b want %b", c, slv_arvalid, busy, m_full); end
            if (exp_pop) begin
                b = sb.pop_front();
                n_cmp++; if (slv_arid !== b.id || slv_araddr !== b.addr) begin n_err++; $display("FAIL rr_beat c%0d: got id %0d addr %h want id %0d addr %h", c, slv_arid, slv_araddr, b.id, b.addr); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        beat_t b;
        do_reset();
        for (int i = 0; i < N; i++) mst_araddr[i*AW +: AW] = 32'hA000 + 32'(16 * i);
        apply(1'b1, 4'b0001, 1'b0);
        n_cmp++; if (mst_arready !== 4'b0001) begin n_err++; $display("FAIL bp_capture: got %b want 0001", mst_arready); end
        step();
        for (int c = 0; c < 5; c++) begin
            apply(1'b1, 4'b0110, 1'b0);
            n_cmp++; if (mst_arready !== 4'b0000) begin n_err++; $display("FAIL bp_ready c%0d: got %b want 0000", c, mst_arready); end
            n_cmp++; if (slv_arvalid !== 1'b1 || slv_araddr !== 32'hA000 || slv_arid !== 2'd0) begin n_err++; $display("FAIL bp_hold c%0d: got v%b addr %h id %0d want v1 addr a000 id 0", c, slv_arvalid, slv_araddr, slv_arid); end
            step();
        end
        apply(1'b1, 4'b0110, 1'b1);
        n_cmp++; if (mst_arready !== 4'b0010 || mst_arready !== exp_rdy) begin n_err++; $display("FAIL bp_release_ready: got %b want 0010", mst_arready); end
        if (exp_pop) begin
            b = sb.pop_front();
            n_cmp++; if (slv_arid !== b.id || slv_araddr !== b.addr) begin n_err++; $display("FAIL bp_beat0: got id %0d addr %h want id %0d addr %h", slv_arid, slv_araddr, b.id, b.addr); end
        end
        step();
        apply(1'b1, 4'b0000, 1'b1);
        if (exp_pop) begin
            b = sb.pop_front();
            n_cmp++; if (slv_arid !== b.id || slv_araddr !== b.addr) begin n_err++; $display("FAIL bp_beat1: got id %0d addr %h want id %0d addr %h", slv_arid, slv_araddr, b.id, b.addr); end
        end
        step();
    endtask

    task automatic test_enable();
        logic [5:0] tbl [8] = '{6'b1_0001_0, 6'b0_0110_0, 6'b0_0110_1, 6'b0_0110_1,
                                6'b0_0110_0, 6'b1_0110_1, 6'b1_0100_1, 6'b1_0000_1};
        logic [N-1:0] want [8] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000,
                                   4'b0000, 4'b0010, 4'b0100, 4'b0000};
        logic [5:0] t;
        beat_t b;
        do_reset();
        for (int i = 0; i < N; i++) mst_araddr[i*AW +: AW] = 32'hE000_0000 + 32'(i);
        for (int c = 0; c < 8; c++) begin
            t = tbl[c];
            apply(t[5], t[4:1], t[0]);
            n_cmp++; if (mst_arready !== exp_rdy || mst_arready !== want[c]) begin n_err++; $display("FAIL en_ready c%0d: got %b want %b", c, mst_arready, want[c]); end
            n_cmp++; if (slv_arvalid !== m_full || busy !== m_full) begin n_err++; $display("FAIL en_valid c%0d: got %b/%b want %b", c, slv_arvalid, busy, m_full); end
            if (exp_pop) begin
                b = sb.pop_front();
                n_cmp++; if (slv_arid !== b.id || slv_araddr !== b.addr) begin n_err++; $display("FAIL en_beat c%0d: got id %0d addr %h want id %0d addr %h", c, slv_arid, slv_araddr, b.id, b.addr); end
            end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] vt   [5] = '{4'b1000, 4'b0000, 4'b1001, 4'b1001, 4'b0000};
        logic [N-1:0] want [5] = '{4'b1000, 4'b0000, 4'b0001, 4'b1000, 4'b0000};
        beat_t b;
        for (int i = 0; i < N; i++) mst_araddr[i*AW +: AW] = 32'h0300_0000 + 32'(i << 8);
        for (int c = 0; c < 5; c++) begin
            apply(1'b1, vt[c], 1'b1);
            n_cmp++; if (mst_arready !== exp_rdy || mst_arready !== want[c]) begin n_err++; $display("FAIL wrap_ready c%0d: got %b want %b", c, mst_arready, want[c]); end
            n_cmp++; if (slv_arvalid !== m_full) begin n_err++; $display("FAIL wrap_valid c%0d: got %b want %b", c, slv_arvalid, m_full); end
            if (exp_pop) begin
                b = sb.pop_front();
                n_cmp++; if (slv_arid !== b.id || slv_araddr !== b.addr) begin n_err++; $display("FAIL wrap_beat c%0d: got id %0d addr %h want id %0d addr %h", c, slv_arid, slv_araddr, b.id, b.addr); end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        beat_t b;
        do_reset();
        for (int i = 0; i < N; i++) mst_araddr[i*AW +: AW] = 32'h7700 + 32'(i);
        apply(1'b1, 4'b0100, 1'b0);
        step();
        apply(1'b1, 4'b0100, 1'b0);
        n_cmp++; if (slv_arvalid !== 1'b1 || slv_arid !== 2'd2 || slv_araddr !== 32'h7702) begin n_err++; $display("FAIL mid_full: got v%b id %0d addr %h want v1 id 2 addr 7702", slv_arvalid, slv_arid, slv_araddr); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (slv_arvalid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_arvalid: got %b/%b want 0", slv_arvalid, busy); end
        n_cmp++; if (slv_araddr !== '0 || slv_arid !== '0) begin n_err++; $display("FAIL mid_data: got addr %h id %0d want 0/0", slv_araddr, slv_arid); end
        n_cmp++; if (mst_arready !== '0) begin n_err++; $display("FAIL mid_ready: got %b want 0000", mst_arready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        apply(1'b1, 4'b1010, 1'b1);
        n_cmp++; if (mst_arready !== 4'b0010 || mst_arready !== exp_rdy) begin n_err++; $display("FAIL mid_regrant: got %b want 0010", mst_arready); end
        step();
        apply(1'b1, 4'b0000, 1'b1);
        if (exp_pop) begin
            b = sb.pop_front();
            n_cmp++; if (slv_arid !== b.id || slv_araddr !== b.addr) begin n_err++; $display("FAIL mid_beat: got id %0d addr %h want id %0d addr %h", slv_arid, slv_araddr, b.id, b.addr); end
        end
        step();
    endtask

    task automatic test_random();
        beat_t b;
        do_reset();
        for (int c = 0; c < 320; c++) begin
            for (int i = 0; i < N; i++) mst_araddr[i*AW +: AW] = $urandom;
            if (c < 300) apply(($urandom % 6) != 0, N'($urandom), ($urandom % 3) != 0);
            else apply(1'b1, 4'b0000, 1'b1);
            n_cmp++; if (mst_arready !== exp_rdy) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, mst_arready, exp_rdy); end
            n_cmp++; if (slv_arvalid !== m_full || busy !== m_full) begin n_err++; $display("FAIL rnd_valid c%0d: got %b/%b want %b", c, slv_arvalid, busy, m_full); end
            if (exp_pop) begin
                b = sb.pop_front();
                n_cmp++; if (slv_arid !== b.id || slv_araddr !== b.addr) begin n_err++; $display("FAIL rnd_beat c%0d: got id %0d addr %h want id %0d addr %h", c, slv_arid, slv_araddr, b.id, b.addr); end
            end
            step();
        end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL rnd_drain: got %0d beats left want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_enable();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
